mem_ctrl: RTL and testbench

- Single-port memory controller between the CPU core's fetch (IF) and memory-access (MEM) stages and the byte-wide system RAM inside the min SOPC.
- Serialises 32-bit instruction fetches and 1/2/4-byte data loads and stores into little-endian byte transactions.
- Arbitrates the two requesters with MEM priority and returns one-cycle completion pulses that the core uses to release its stall.

---
 rtl/mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//
// Single-port memory controller that sits between the core's instruction
// fetch (IF) and memory-access (MEM) stages and the byte-wide system RAM.
// Every 32-bit fetch and every 1/2/4-byte load or store is broken into a
// sequence of little-endian byte accesses. When both stages ask in the same
// cycle, MEM wins. The other request is still pending and is served in a
// later transaction of its own. Each transaction ends with a one-cycle done
// pulse that releases the requesting stage from its stall.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   if_req     fetch request, held until if_done
//   if_addr    fetch byte address
//   if_done    one-cycle fetch completion pulse
//   if_data    fetched word, valid while if_done is high, held afterwards
//   mem_req    data request, held until mem_done
//   mem_we     1 = store, 0 = load
//   mem_size   00 byte, 01 halfword, 10/11 word
//   mem_addr   data byte address
//   mem_wdata  store data, low byte first
//   mem_done   one-cycle data completion pulse
//   mem_rdata  zero-extended load data, held until the next load completes
//   busy       high whenever the controller is not idle
//   ram_addr   RAM byte address
//   ram_wr     RAM write strobe for the byte currently presented
//   ram_dout   RAM write data
//   ram_din    RAM read data, valid one cycle after ram_addr
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int RAM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic        busy,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   // The capture timing below assumes RAM read data arrives exactly one
   // cycle after the address. Any other latency would need a different
   // schedule, so it is refused at elaboration time.
   if (RAM_LATENCY != 1) begin : g_latency_check
      $error("mem_ctrl: only RAM_LATENCY = 1 is supported");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_n;
   logic [31:0] base_addr, base_addr_n;
   logic [31:0] wdata_r, wdata_n;
   logic        we_r, we_n;
   logic        src_mem, src_mem_n;
   logic [2:0]  n_bytes, n_bytes_n;
   logic [2:0]  cnt, cnt_n;
   logic [31:0] cap_buf, cap_buf_n;

   logic        if_done_n, mem_done_n, busy_n, ram_wr_n;
   logic [31:0] if_data_n, mem_rdata_n, ram_addr_n;
   logic [7:0]  ram_dout_n;

   logic [31:0] assembled;
   logic [1:0]  rd_sel, wr_sel;
   logic        last;

   // All registers, including every output, are loaded from the next-value
   // logic below. A reset aborts any transaction in flight. Bytes already
   // written to the RAM stay written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base_addr <= '0;
         wdata_r   <= '0;
         we_r      <= 1'b0;
         src_mem   <= 1'b0;
         n_bytes   <= '0;
         cnt       <= '0;
         cap_buf   <= '0;
         if_done   <= 1'b0;
         if_data   <= '0;
         mem_done  <= 1'b0;
         mem_rdata <= '0;
         busy      <= 1'b0;
         ram_addr  <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= '0;
      end else begin
         state     <= state_n;
         base_addr <= base_addr_n;
         wdata_r   <= wdata_n;
         we_r      <= we_n;
         src_mem   <= src_mem_n;
         n_bytes   <= n_bytes_n;
         cnt       <= cnt_n;
         cap_buf   <= cap_buf_n;
         if_done   <= if_done_n;
         if_data   <= if_data_n;
         mem_done  <= mem_done_n;
         mem_rdata <= mem_rdata_n;
         busy      <= busy_n;
         ram_addr  <= ram_addr_n;
         ram_wr    <= ram_wr_n;
         ram_dout  <= ram_dout_n;
      end
   end

   // Next-state and next-output logic.
   //
   // While in ACCESS, cnt = k marks cycle A+1+k. During that cycle byte k is
   // on the RAM port, and ram_din carries byte k-1 that was issued one cycle
   // earlier. A store finishes once its last byte is on the port. A load
   // needs one more cycle to capture its last byte. The next byte is issued
   // in the same step that decides whether the transaction is finished.
   always_comb begin
      state_n     = state;
      base_addr_n = base_addr;
      wdata_n     = wdata_r;
      we_n        = we_r;
      src_mem_n   = src_mem;
      n_bytes_n   = n_bytes;
      cnt_n       = cnt;
      cap_buf_n   = cap_buf;
      if_done_n   = 1'b0;
      if_data_n   = if_data;
      mem_done_n  = 1'b0;
      mem_rdata_n = mem_rdata;
      ram_addr_n  = ram_addr;
      ram_wr_n    = 1'b0;
      ram_dout_n  = ram_dout;
      assembled   = cap_buf;
      rd_sel      = 2'(cnt - 3'd1);
      wr_sel      = 2'(cnt + 3'd1);
      last        = 1'b0;

      case (state)
         IDLE: begin
            if (mem_req || if_req) begin
               src_mem_n   = mem_req;
               base_addr_n = mem_req ? mem_addr : if_addr;
               we_n        = mem_req & mem_we;
               wdata_n     = mem_req ? mem_wdata : 32'd0;
               if (!mem_req)
                  n_bytes_n = 3'd4;
               else if (mem_size == 2'b00)
                  n_bytes_n = 3'd1;
               else if (mem_size == 2'b01)
                  n_bytes_n = 3'd2;
               else
                  n_bytes_n = 3'd4;
               cnt_n       = '0;
               cap_buf_n   = '0;
               ram_addr_n  = mem_req ? mem_addr : if_addr;
               ram_wr_n    = mem_req & mem_we;
               ram_dout_n  = mem_req ? mem_wdata[7:0] : 8'd0;
               state_n     = ACCESS;
            end
         end

         ACCESS: begin
            if (!we_r && cnt != 3'd0)
               assembled[{rd_sel, 3'b000} +: 8] = ram_din;
            cap_buf_n = assembled;

            if (cnt + 3'd1 < n_bytes) begin
               ram_addr_n = base_addr + {29'd0, cnt} + 32'd1;
               ram_wr_n   = we_r;
               ram_dout_n = wdata_r[{wr_sel, 3'b000} +: 8];
            end

            last = we_r ? (cnt == n_bytes - 3'd1) : (cnt == n_bytes);
            if (last) begin
               state_n = DONE;
               cnt_n   = '0;
               if (src_mem) begin
                  mem_done_n = 1'b1;
                  if (!we_r)
                     mem_rdata_n = assembled;
               end else begin
                  if_done_n = 1'b1;
                  if_data_n = assembled;
               end
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//
// Directed testbench for mem_ctrl. A small byte-wide RAM model answers one
// cycle after each address. Its contents are preloaded through a side port
// so that every write to the array happens in one process. The directed
// steps cover:
//   - a word fetch
//   - a byte store and a halfword load
//   - simultaneous requests, where the MEM request has priority
//   - address wrap-around
//   - a reset in the middle of a store
// Each step is compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        busy;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   logic        tb_load_en;
   logic [15:0] tb_load_addr;
   logic [7:0]  tb_load_data;
   logic [7:0]  ram [0:65535];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   mem_ctrl #(.RAM_LATENCY(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_data   (if_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_wr    (ram_wr),
      .ram_dout  (ram_dout),
      .ram_din   (ram_din)
   );

   always #5 clk = ~clk;

   // Byte-wide synchronous RAM. The low 16 address bits index the array,
   // which is enough to keep every address used here distinct, including
   // the wrapped ones.
   always @(posedge clk) begin
      if (tb_load_en)
         ram[tb_load_addr] <= tb_load_data;
      else if (ram_wr)
         ram[ram_addr[15:0]] <= ram_dout;
      ram_din <= ram[ram_addr[15:0]];
   end

   // Stops the run if it ever fails to finish on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advances the given number of clock cycles. Afterwards the bench sits
   // just after the rising edge, so the outputs registered on that edge can
   // be read and new inputs can be applied.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic loadByte(input logic [15:0] a, input logic [7:0] d);
      tb_load_en   = 1'b1;
      tb_load_addr = a;
      tb_load_data = d;
      applyStimulus(1);
      tb_load_en   = 1'b0;
   endtask

   initial begin
      logic [31:0] wd;
      logic [31:0] exp_a;

      rst          = 1'b1;
      if_req       = 1'b0;
      if_addr      = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_size     = 2'b00;
      mem_addr     = '0;
      mem_wdata    = '0;
      tb_load_en   = 1'b0;
      tb_load_addr = '0;
      tb_load_data = '0;

      // Preload the RAM while the controller is held in reset.
      applyStimulus(1);
      loadByte(16'h0100, 8'h13);
      loadByte(16'h0101, 8'h05);
      loadByte(16'h0102, 8'h10);
      loadByte(16'h0103, 8'h00);
      loadByte(16'h2000, 8'h34);
      loadByte(16'h2001, 8'hF2);
      loadByte(16'h2002, 8'h5A);
      loadByte(16'hFFFE, 8'hA1);
      loadByte(16'hFFFF, 8'hB2);
      loadByte(16'h0000, 8'hC3);
      loadByte(16'h0001, 8'hD4);
      for (int i = 0; i < 4; i++) begin
         loadByte(16'h0040 + 16'(i), 8'h00);
         loadByte(16'h0300 + 16'(i), 8'h00);
      end

      // Reset state.
      checkOutput("reset if_done",   {31'd0, if_done},  32'd0);
      checkOutput("reset if_data",   if_data,           32'd0);
      checkOutput("reset mem_done",  {31'd0, mem_done}, 32'd0);
      checkOutput("reset mem_rdata", mem_rdata,         32'd0);
      checkOutput("reset busy",      {31'd0, busy},     32'd0);
      checkOutput("reset ram_addr",  ram_addr,          32'd0);
      checkOutput("reset ram_wr",    {31'd0, ram_wr},   32'd0);
      checkOutput("reset ram_dout",  {24'd0, ram_dout}, 32'd0);
      rst = 1'b0;
      applyStimulus(1);

      // Word fetch from 0x100.
      $display("[TB] word fetch");
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1);
         checkOutput("fetch ram_addr", ram_addr, 32'h100 + 32'(i));
         checkOutput("fetch ram_wr", {31'd0, ram_wr}, 32'd0);
         checkOutput("fetch busy", {31'd0, busy}, 32'd1);
      end
      applyStimulus(1);
      checkOutput("fetch done early", {31'd0, if_done}, 32'd0);
      applyStimulus(1);
      checkOutput("fetch if_done", {31'd0, if_done}, 32'd1);
      checkOutput("fetch if_data", if_data, 32'h0010_0513);
      if_req = 1'b0;
      applyStimulus(1);
      checkOutput("fetch done pulse", {31'd0, if_done}, 32'd0);
      checkOutput("fetch idle busy", {31'd0, busy}, 32'd0);
      checkOutput("fetch data held", if_data, 32'h0010_0513);

      // Byte store to 0x2001.
      $display("[TB] byte store");
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_size  = 2'b00;
      mem_addr  = 32'h0000_2001;
      mem_wdata = 32'hAABB_CCDD;
      applyStimulus(1);
      checkOutput("sb ram_wr", {31'd0, ram_wr}, 32'd1);
      checkOutput("sb ram_addr", ram_addr, 32'h2001);
      checkOutput("sb ram_dout", {24'd0, ram_dout}, 32'hDD);
      applyStimulus(1);
      checkOutput("sb mem_done", {31'd0, mem_done}, 32'd1);
      checkOutput("sb ram_wr off", {31'd0, ram_wr}, 32'd0);
      mem_req = 1'b0;
      mem_we  = 1'b0;
      applyStimulus(1);
      checkOutput("sb done pulse", {31'd0, mem_done}, 32'd0);
      checkOutput("sb ram 2001", {24'd0, ram[16'h2001]}, 32'hDD);
      checkOutput("sb ram 2000", {24'd0, ram[16'h2000]}, 32'h34);
      checkOutput("sb ram 2002", {24'd0, ram[16'h2002]}, 32'h5A);
      checkOutput("sb rdata kept", mem_rdata, 32'd0);

      // Halfword load from 0x2000.
      $display("[TB] halfword load");
      loadByte(16'h2001, 8'hF2);
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_size = 2'b01;
      mem_addr = 32'h0000_2000;
      applyStimulus(3);
      checkOutput("lh done early", {31'd0, mem_done}, 32'd0);
      applyStimulus(1);
      checkOutput("lh mem_done", {31'd0, mem_done}, 32'd1);
      checkOutput("lh mem_rdata", mem_rdata, 32'h0000_F234);
      mem_req = 1'b0;
      applyStimulus(1);

      // Simultaneous requests: the word store to 0x40 goes first.
      $display("[TB] simultaneous requests");
      wd        = 32'h1122_3344;
      if_req    = 1'b1;
      if_addr   = 32'h0000_0100;
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_size  = 2'b10;
      mem_addr  = 32'h0000_0040;
      mem_wdata = wd;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1);
         checkOutput("sw ram_wr", {31'd0, ram_wr}, 32'd1);
         checkOutput("sw ram_addr", ram_addr, 32'h40 + 32'(i));
         checkOutput("sw ram_dout", {24'd0, ram_dout}, {24'd0, 8'(wd >> (8 * i))});
      end
      applyStimulus(1);
      checkOutput("sw mem_done", {31'd0, mem_done}, 32'd1);
      checkOutput("sw if_done", {31'd0, if_done}, 32'd0);
      checkOutput("sw rdata kept", mem_rdata, 32'h0000_F234);
      mem_req = 1'b0;
      mem_we  = 1'b0;
      applyStimulus(1);
      checkOutput("arb idle gap busy", {31'd0, busy}, 32'd0);
      checkOutput("arb mem_done off", {31'd0, mem_done}, 32'd0);
      applyStimulus(1);
      checkOutput("arb fetch addr", ram_addr, 32'h100);
      checkOutput("arb fetch busy", {31'd0, busy}, 32'd1);
      applyStimulus(4);
      checkOutput("arb if_done early", {31'd0, if_done}, 32'd0);
      applyStimulus(1);
      checkOutput("arb if_done", {31'd0, if_done}, 32'd1);
      checkOutput("arb if_data", if_data, 32'h0010_0513);
      if_req = 1'b0;
      checkOutput("sw ram 40", {24'd0, ram[16'h0040]}, 32'h44);
      checkOutput("sw ram 43", {24'd0, ram[16'h0043]}, 32'h11);
      applyStimulus(1);

      // Word load crossing the top of the address space.
      $display("[TB] wrap-around load");
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_size = 2'b10;
      mem_addr = 32'hFFFF_FFFE;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1);
         exp_a = 32'hFFFF_FFFE + 32'(i);
         checkOutput("wrap ram_addr", ram_addr, exp_a);
      end
      applyStimulus(1);
      checkOutput("wrap done early", {31'd0, mem_done}, 32'd0);
      applyStimulus(1);
      checkOutput("wrap mem_done", {31'd0, mem_done}, 32'd1);
      checkOutput("wrap mem_rdata", mem_rdata, 32'hD4C3_B2A1);
      mem_req = 1'b0;
      applyStimulus(1);

      // Reset in the middle of a word store to 0x300.
      $display("[TB] reset mid-store");
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_size  = 2'b10;
      mem_addr  = 32'h0000_0300;
      mem_wdata = 32'h5566_7788;
      applyStimulus(1);
      checkOutput("rs byte0 wr", {31'd0, ram_wr}, 32'd1);
      checkOutput("rs byte0 addr", ram_addr, 32'h300);
      applyStimulus(1);
      checkOutput("rs byte1 addr", ram_addr, 32'h301);
      rst     = 1'b1;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      applyStimulus(1);
      checkOutput("rs ram_wr", {31'd0, ram_wr}, 32'd0);
      checkOutput("rs busy", {31'd0, busy}, 32'd0);
      checkOutput("rs mem_done", {31'd0, mem_done}, 32'd0);
      rst = 1'b0;
      applyStimulus(1);
      checkOutput("rs no done", {31'd0, mem_done}, 32'd0);
      checkOutput("rs idle", {31'd0, busy}, 32'd0);
      checkOutput("rs ram 300", {24'd0, ram[16'h0300]}, 32'h88);
      checkOutput("rs ram 301", {24'd0, ram[16'h0301]}, 32'h77);
      checkOutput("rs ram 302", {24'd0, ram[16'h0302]}, 32'h00);

      // A fetch after the reset completes normally.
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      applyStimulus(1);
      checkOutput("post-rst addr", ram_addr, 32'h100);
      applyStimulus(5);
      checkOutput("post-rst if_done", {31'd0, if_done}, 32'd1);
      checkOutput("post-rst if_data", if_data, 32'h0010_0513);
      if_req = 1'b0;
      applyStimulus(1);
      checkOutput("post-rst done pulse", {31'd0, if_done}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
